// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared constants and state encoding for the CDC handshake blocks
package cdc_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } hs_state_e;

   localparam int CDC_MIN_STAGES      = 2;
   localparam int CDC_DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/cdc_synchronizer.sv
// rtl/cdc_synchronizer.sv - single-bit multi-flop synchronizer with configurable reset value
module cdc_synchronizer
   import cdc_pkg::*;
#(
   parameter int   NUM_STAGES = 2,
   parameter logic INIT_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   // Depth below the metastability minimum is silently raised to it.
   localparam int STAGES = (NUM_STAGES < CDC_MIN_STAGES) ? CDC_MIN_STAGES : NUM_STAGES;

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{INIT_VALUE}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_src.sv
// rtl/cdc_handshake_src.sv - source half of a two-phase req/ack multi-bit crossing
// Optional ack-wait watchdog enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_handshake_src
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_STAGES     = 2,
   parameter int TIMEOUT_CYCLES = CDC_DEFAULT_TIMEOUT
) (
   input  logic                  clk_src,
   input  logic                  rst_src_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic                  bus_req,
   input  logic                  ack_toggle,
   output logic                  done,
   output logic                  timeout_err
);

   hs_state_e state;
   hs_state_e state_next;
   logic      ack_s;
   logic      ack_match;
   logic      accept;
   logic      finish;

   cdc_synchronizer #(
      .NUM_STAGES (NUM_STAGES),
      .INIT_VALUE (1'b0)
   ) u_ack_sync (
      .clk   (clk_src),
      .rst_n (rst_src_n),
      .d     (ack_toggle),
      .q     (ack_s)
   );

   // Gating on ack_match keeps a spurious or stale ack toggle from letting a word in.
   assign ack_match = (ack_s == bus_req);
   assign in_ready  = (state == IDLE) && ack_match;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept     = 1'b1;
               state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_match) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_src or negedge rst_src_n) begin
      if (!rst_src_n) begin
         state    <= IDLE;
         bus_req  <= 1'b0;
         bus_data <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_next;
         done  <= finish;
         if (accept) begin
            bus_data <= in_data;
            bus_req  <= ~bus_req;
         end
      end
   end

`ifdef CDC_HS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Watchdog only flags; the transfer keeps waiting for its ack.
   always_ff @(posedge clk_src or negedge rst_src_n) begin
      if (!rst_src_n) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if ((state == WAIT_ACK) && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
         wait_cnt <= wait_cnt + 1'b1;
         if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_src.sv
// tb/tb_cdc_handshake_src.sv - directed table and sequence bench for cdc_handshake_src
module tb_cdc_handshake_src;

   logic       clk_src;
   logic       rst_src_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] bus_data;
   logic       bus_req;
   logic       ack_toggle;
   logic       done;
   logic       timeout_err;

   int n_cmp;
   int n_fail;

   cdc_handshake_src #(
      .DATA_WIDTH     (8),
      .NUM_STAGES     (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_src     (clk_src),
      .rst_src_n   (rst_src_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .bus_data    (bus_data),
      .bus_req     (bus_req),
      .ack_toggle  (ack_toggle),
      .done        (done),
      .timeout_err (timeout_err)
   );

   initial clk_src = 1'b0;
   always #5 clk_src = ~clk_src;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ack;
      logic       rdy;
      logic       req;
      logic [7:0] bd;
      logic       dn;
   } vec_t;

   vec_t tbl [25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_src);
      #1;
   endtask

   task automatic reset_dut();
      rst_src_n  = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      ack_toggle = 1'b0;
      repeat (3) @(posedge clk_src);
      #1;
      rst_src_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] words [3];
      logic [7:0] last_data;
      logic       exp_req;
      logic       acc;
      logic       prev_req;
      logic       got_done;
      int         idx;
      int         dones;
      int         dly;

      n_cmp  = 0;
      n_fail = 0;

      //        v  d      ack  rdy req bd     dn
      tbl[0]  = '{1, 8'hA5, 0,  0,  1, 8'hA5, 0};
      tbl[1]  = '{0, 8'hA5, 0,  0,  1, 8'hA5, 0};
      tbl[2]  = '{0, 8'hA5, 0,  0,  1, 8'hA5, 0};
      tbl[3]  = '{0, 8'hA5, 1,  0,  1, 8'hA5, 0};
      tbl[4]  = '{0, 8'hA5, 1,  0,  1, 8'hA5, 0};
      tbl[5]  = '{0, 8'hA5, 1,  1,  1, 8'hA5, 1};
      tbl[6]  = '{0, 8'hA5, 1,  1,  1, 8'hA5, 0};
      tbl[7]  = '{1, 8'h3C, 1,  0,  0, 8'h3C, 0};
      tbl[8]  = '{1, 8'hFF, 1,  0,  0, 8'h3C, 0};
      tbl[9]  = '{1, 8'hFF, 1,  0,  0, 8'h3C, 0};
      tbl[10] = '{1, 8'hFF, 0,  0,  0, 8'h3C, 0};
      tbl[11] = '{1, 8'hFF, 0,  0,  0, 8'h3C, 0};
      tbl[12] = '{1, 8'hFF, 0,  1,  0, 8'h3C, 1};
      tbl[13] = '{1, 8'hFF, 0,  0,  1, 8'hFF, 0};
      tbl[14] = '{0, 8'hFF, 0,  0,  1, 8'hFF, 0};
      tbl[15] = '{0, 8'hFF, 1,  0,  1, 8'hFF, 0};
      tbl[16] = '{0, 8'hFF, 1,  0,  1, 8'hFF, 0};
      tbl[17] = '{0, 8'hFF, 1,  1,  1, 8'hFF, 1};
      tbl[18] = '{0, 8'hFF, 1,  1,  1, 8'hFF, 0};
      tbl[19] = '{0, 8'hFF, 0,  1,  1, 8'hFF, 0};
      tbl[20] = '{0, 8'hFF, 0,  0,  1, 8'hFF, 0};
      tbl[21] = '{1, 8'h77, 0,  0,  1, 8'hFF, 0};
      tbl[22] = '{1, 8'h77, 1,  0,  1, 8'hFF, 0};
      tbl[23] = '{0, 8'h77, 1,  1,  1, 8'hFF, 0};
      tbl[24] = '{0, 8'h77, 1,  1,  1, 8'hFF, 0};

      reset_dut();
      chk("reset bus_req", 32'(bus_req), 32'h0);
      chk("reset bus_data", 32'(bus_data), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);
      chk("reset done", 32'(done), 32'h0);
      chk("reset timeout_err", 32'(timeout_err), 32'h0);

      // Single transfer, stall with changing in_data, spurious ack while idle.
      for (int i = 0; i < 25; i++) begin
         in_valid   = tbl[i].v;
         in_data    = tbl[i].d;
         ack_toggle = tbl[i].ack;
         tick();
         chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         chk($sformatf("row%0d bus_req", i), 32'(bus_req), 32'(tbl[i].req));
         chk($sformatf("row%0d bus_data", i), 32'(bus_data), 32'(tbl[i].bd));
         chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].dn));
         chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'h0);
      end

      // Asynchronous reset in the middle of a transfer.
      reset_dut();
      in_valid = 1'b1;
      in_data  = 8'h9C;
      tick();
      in_valid = 1'b0;
      chk("midrst accept bus_req", 32'(bus_req), 32'h1);
      chk("midrst accept bus_data", 32'(bus_data), 32'h9C);
      chk("midrst accept in_ready", 32'(in_ready), 32'h0);
      @(posedge clk_src);
      #3;
      rst_src_n = 1'b0;
      #1;
      chk("midrst bus_req", 32'(bus_req), 32'h0);
      chk("midrst bus_data", 32'(bus_data), 32'h0);
      chk("midrst in_ready", 32'(in_ready), 32'h1);
      chk("midrst done", 32'(done), 32'h0);

      // Back-to-back with a destination model acking 3 cycles after each req edge.
      reset_dut();
      words[0]  = 8'h01;
      words[1]  = 8'h02;
      words[2]  = 8'h03;
      idx       = 0;
      dones     = 0;
      dly       = -1;
      exp_req   = 1'b0;
      last_data = 8'h00;
      in_valid  = 1'b1;
      in_data   = words[0];
      for (int cyc = 0; cyc < 200; cyc++) begin
         acc      = in_valid && in_ready;
         prev_req = bus_req;
         tick();
         if (done) dones++;
         if (acc) begin
            exp_req = ~exp_req;
            chk($sformatf("b2b word%0d bus_req", idx), 32'(bus_req), 32'(exp_req));
            chk($sformatf("b2b word%0d bus_data", idx), 32'(bus_data), 32'(words[idx]));
            chk($sformatf("b2b word%0d after done", idx), 32'(dones), 32'(idx));
            last_data = words[idx];
            idx++;
            if (idx == 3) in_valid = 1'b0;
            else          in_data  = words[idx];
         end else if (bus_data !== last_data) begin
            chk("b2b bus_data held", 32'(bus_data), 32'(last_data));
         end
         if (bus_req != prev_req) begin
            dly = 3;
         end else if (dly > 0) begin
            dly--;
         end
         if (dly == 0) begin
            ack_toggle = bus_req;
            dly        = -1;
         end
         if (idx == 3 && dones == 3) break;
      end
      chk("b2b words accepted", 32'(idx), 32'd3);
      chk("b2b done pulses", 32'(dones), 32'd3);
      chk("b2b final in_ready", 32'(in_ready), 32'h1);

`ifdef CDC_HS_TIMEOUT_EN
      reset_dut();
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
      in_valid = 1'b0;
      chk("tmo accept bus_req", 32'(bus_req), 32'h1);
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk($sformatf("tmo cycle%0d clear", k), 32'(timeout_err), 32'h0);
      end
      tick();
      chk("tmo cycle16 set", 32'(timeout_err), 32'h1);
      repeat (4) tick();
      chk("tmo sticky", 32'(timeout_err), 32'h1);
      chk("tmo still waiting", 32'(in_ready), 32'h0);
      ack_toggle = 1'b1;
      got_done   = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done) begin
            got_done = 1'b1;
            break;
         end
      end
      chk("tmo late ack done", 32'(got_done), 32'h1);
      chk("tmo sticky after done", 32'(timeout_err), 32'h1);
      tick();
      chk("tmo in_ready after done", 32'(in_ready), 32'h1);
      reset_dut();
      chk("tmo cleared by reset", 32'(timeout_err), 32'h0);
`else
      got_done = 1'b0;
      chk("tmo disabled flag", 32'(timeout_err | got_done), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
